imm_gen_pipe: RTL and testbench
===============================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath width of the immediate; the block SHALL support only the values 32 and 64.
REQ-002 Parameter TAG_W, default 32, width of the sideband tag (PC) carried with each instruction.
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  reset; it SHALL be synchronous and active-high.
REQ-005 Port flush  input  1  discards all buffered entries.
REQ-006 Port in_valid  input  1  upstream has an instruction.
REQ-007 Port in_ready  output  1  block can accept an instruction.
REQ-008 Port in_instr  input  32  raw instruction; the opcode SHALL be taken internally from in_instr[6:0].
REQ-009 Port in_tag  input  TAG_W  sideband tag.
REQ-010 Port out_valid  output  1  output entry is valid.
REQ-011 Port out_ready  input  1  downstream accepts the entry.
REQ-012 Port out_imm  output  XLEN  decoded immediate.
REQ-013 Port out_fmt  output  3  format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z.
REQ-014 Port out_illegal  output  1  opcode is unrecognised, or instr[1:0] is not 2'b11.
REQ-015 Port out_instr / out_tag  output  32 / TAG_W  input fields passed through unchanged.

Function
REQ-016 Decode by opcode:
- I format: 0000011, 0010011, 1100111, 0001111; also 0011011 when XLEN=64.
- S format: 0100011.
- B format: 1100011.
- U format: 0110111, 0010111.
- J format: 1101111.
- SYSTEM (1110011):
  - funct3 = 101/110/111 -> Z.
  - funct3 = 100 -> NONE, illegal.
  - other funct3 -> NONE.
- R format: 0110011; also 0111011 when XLEN=64; gives NONE, legal.
REQ-017 Immediates, sign-extended from instr[31] to XLEN unless stated otherwise:
- I = instr[31:20].
- S = {instr[31:25], instr[11:7]}.
- B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- U = {instr[31:12], 12'b0}.
- J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- Z = instr[19:15], zero-extended.
REQ-018 Whenever out_fmt is NONE, out_imm SHALL be 0; when out_illegal is 1, out_fmt SHALL be NONE.
REQ-019 The datapath SHALL be a 2-entry elastic buffer: a main register driving the outputs, plus a skid register.
REQ-020 Latency: an input accepted in cycle N (in_valid and in_ready both high) SHALL appear on the outputs in cycle N+1 when the buffer was empty.
REQ-021 in_ready SHALL be a registered signal equal to NOT(skid register full); it SHALL NOT depend combinationally on out_ready.
REQ-022 Entry states: EMPTY (out_valid=0), ONE (main full), TWO (main and skid full).
REQ-023 EMPTY transitions: on accept -> ONE.
REQ-024 ONE transitions:
- accept with out_ready -> ONE, main reloads.
- accept without out_ready -> TWO, new entry goes to skid.
- out_ready without accept -> EMPTY.
REQ-025 TWO transitions: on out_ready -> ONE, skid moves to main; no accept is possible because in_ready=0.
REQ-026 Decode SHALL occur before the register, so registered outputs carry final values.
REQ-027 While out_valid=1 and out_ready=0, every output SHALL hold stable.
REQ-028 Ordering: entries SHALL leave in acceptance order; no entry SHALL be dropped or duplicated.
REQ-029 flush=1 SHALL force the EMPTY state next cycle and discard any input accepted in the same cycle; in_ready SHALL be 1 the cycle after.
REQ-030 If rst and flush are both high, rst SHALL take priority; the result is identical to reset.

Reset
REQ-031 Values after reset:
- out_valid = 0, in_ready = 1.
- out_imm = 0, out_fmt = 0, out_illegal = 0, out_instr = 0, out_tag = 0.
- skid register empty.
REQ-032 A reset asserted mid-stall, in state TWO, SHALL discard both entries within one cycle.
REQ-033 No input SHALL be accepted in a cycle where rst=1.

Verification
REQ-034 Basic decode, XLEN=32, out_ready=1:
- 0xFFF00093 -> out_imm 0xFFFFFFFF, fmt 1, one cycle later.
- 0xFE112E23 -> 0xFFFFFFFC, fmt 2.
- 0xFE000FE3 -> 0xFFFFFFFE, fmt 3.
REQ-035 U, J and Z formats:
- 0x123452B7 -> 0x12345000, fmt 4.
- 0x001000EF -> 0x00000800, fmt 5.
- 0x0002D073 -> 0x00000005, fmt 6.
- 0x00000033 -> 0, fmt 0, illegal 0.
- 0x0000007F -> 0, fmt 0, illegal 1.
REQ-036 XLEN=64: 0x800002B7 -> 0xFFFFFFFF80000000; 0xFFF0009B (opcode 0011011) -> 0xFFFFFFFFFFFFFFFF, fmt 1.
REQ-037 Backpressure:
- Stimulus: out_ready=0; push A (tag 0x10), then B (tag 0x14), then hold C.
- in_ready falls the cycle after B is accepted; C is not accepted.
- Then raise out_ready: outputs are A, B, C in consecutive cycles with correct tags.
REQ-038 Flush and reset in state TWO:
- flush=1 -> next cycle out_valid=0, in_ready=1; an input in the flush cycle never appears.
- Repeat with rst=1 -> all outputs equal the reset values of REQ-031.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RISC-V immediate generator behind a 2-entry elastic buffer.
// Each instruction is decoded before it is registered. The main register
// drives the outputs, and a skid register absorbs one extra entry so that
// in_ready can be a pure register output.

module imm_gen_pipe #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_fmt,
   output logic             out_illegal,
   output logic [31:0]      out_instr,
   output logic [TAG_W-1:0] out_tag
);

   // Buffer occupancy
   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

   // Immediate format codes
   localparam logic [2:0] FMT_NONE = 3'd0;
   localparam logic [2:0] FMT_I    = 3'd1;
   localparam logic [2:0] FMT_S    = 3'd2;
   localparam logic [2:0] FMT_B    = 3'd3;
   localparam logic [2:0] FMT_U    = 3'd4;
   localparam logic [2:0] FMT_J    = 3'd5;
   localparam logic [2:0] FMT_Z    = 3'd6;

   // Major opcodes
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_OP32     = 7'b0111011;

   // One buffered, fully decoded entry
   typedef struct packed {
      logic [XLEN-1:0]  imm;
      logic [2:0]       fmt;
      logic             illegal;
      logic [31:0]      instr;
      logic [TAG_W-1:0] tag;
   } entry_t;

   localparam int     ENTRY_W    = $bits(entry_t);
   localparam entry_t ENTRY_ZERO = entry_t'({ENTRY_W{1'b0}});

   // Classify the instruction into an immediate format and a legality flag
   function automatic logic [3:0] classify(input logic [31:0] instr);
      logic [2:0] fmt;
      logic       ill;
      fmt = FMT_NONE;
      ill = 1'b0;
      if (instr[1:0] != 2'b11) begin
         ill = 1'b1;
      end else begin
         case (instr[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_MISC_MEM: fmt = FMT_I;
            OPC_OP_IMM32: begin
               if (XLEN == 64) fmt = FMT_I;
               else            ill = 1'b1;
            end
            OPC_STORE:           fmt = FMT_S;
            OPC_BRANCH:          fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:  fmt = FMT_U;
            OPC_JAL:             fmt = FMT_J;
            OPC_SYSTEM: begin
               case (instr[14:12])
                  3'b101, 3'b110, 3'b111: fmt = FMT_Z;
                  3'b100:                 ill = 1'b1;
                  default:                fmt = FMT_NONE;
               endcase
            end
            OPC_OP:              fmt = FMT_NONE;
            OPC_OP32: begin
               if (XLEN == 64) fmt = FMT_NONE;
               else            ill = 1'b1;
            end
            default:             ill = 1'b1;
         endcase
      end
      return {fmt, ill};
   endfunction

   // Assemble the immediate for a given format; NONE yields zero
   function automatic logic [XLEN-1:0] build_imm(input logic [31:0] instr,
                                                 input logic [2:0]  fmt);
      logic [XLEN-1:0] r;
      r = {XLEN{instr[31]}};
      case (fmt)
         FMT_I: r[11:0] = instr[31:20];
         FMT_S: r[11:0] = {instr[31:25], instr[11:7]};
         FMT_B: r[12:0] = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         FMT_U: r[31:0] = {instr[31:12], 12'd0};
         FMT_J: r[20:0] = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         FMT_Z: begin
            r      = {XLEN{1'b0}};
            r[4:0] = instr[19:15];
         end
         default: r = {XLEN{1'b0}};
      endcase
      return r;
   endfunction

   logic [1:0] state_r, state_s;
   entry_t     main_r, main_s;
   entry_t     skid_r, skid_s;
   logic       ready_r, ready_s;
   logic       valid_r, valid_s;
   logic [3:0] cls_s;
   entry_t     dec_s;
   logic       accept_s;

   // Decode the incoming instruction ahead of the buffer registers
   always_comb begin
      cls_s         = classify(in_instr);
      dec_s.fmt     = cls_s[3:1];
      dec_s.illegal = cls_s[0];
      dec_s.imm     = build_imm(in_instr, cls_s[3:1]);
      dec_s.instr   = in_instr;
      dec_s.tag     = in_tag;
   end

   assign accept_s = in_valid & ready_r;

   // Next-state and next-contents of the elastic buffer
   always_comb begin
      state_s = state_r;
      main_s  = main_r;
      skid_s  = skid_r;
      if (flush) begin
         state_s = ST_EMPTY;
         main_s  = ENTRY_ZERO;
         skid_s  = ENTRY_ZERO;
      end else begin
         case (state_r)
            ST_EMPTY: begin
               if (accept_s) begin
                  state_s = ST_ONE;
                  main_s  = dec_s;
               end else begin
                  state_s = ST_EMPTY;
               end
            end
            ST_ONE: begin
               if (accept_s && out_ready) begin
                  main_s = dec_s;
               end else if (accept_s) begin
                  state_s = ST_TWO;
                  skid_s  = dec_s;
               end else if (out_ready) begin
                  state_s = ST_EMPTY;
               end else begin
                  state_s = ST_ONE;
               end
            end
            ST_TWO: begin
               // in_ready is low here, so only a drain can happen
               if (out_ready) begin
                  state_s = ST_ONE;
                  main_s  = skid_r;
                  skid_s  = ENTRY_ZERO;
               end else begin
                  state_s = ST_TWO;
               end
            end
            default: begin
               state_s = ST_EMPTY;
               main_s  = ENTRY_ZERO;
               skid_s  = ENTRY_ZERO;
            end
         endcase
      end
      ready_s = (state_s != ST_TWO);
      valid_s = (state_s != ST_EMPTY);
   end

   // Buffer registers; reset overrides flush and blocks any accept
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_EMPTY;
         main_r  <= ENTRY_ZERO;
         skid_r  <= ENTRY_ZERO;
         ready_r <= 1'b1;
         valid_r <= 1'b0;
      end else begin
         state_r <= state_s;
         main_r  <= main_s;
         skid_r  <= skid_s;
         ready_r <= ready_s;
         valid_r <= valid_s;
      end
   end

   assign in_ready    = ready_r;
   assign out_valid   = valid_r;
   assign out_imm     = main_r.imm;
   assign out_fmt     = main_r.fmt;
   assign out_illegal = main_r.illegal;
   assign out_instr   = main_r.instr;
   assign out_tag     = main_r.tag;

   imm_gen_pipe_chk #(.XLEN(XLEN), .TAG_W(TAG_W)) u_chk (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_imm     (out_imm),
      .out_fmt     (out_fmt),
      .out_illegal (out_illegal),
      .out_instr   (out_instr),
      .out_tag     (out_tag)
   );

endmodule

// Protocol and decode invariants of imm_gen_pipe, observed at its ports.
module imm_gen_pipe_chk #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 32
) (
   input logic             clk,
   input logic             rst,
   input logic             flush,
   input logic             in_ready,
   input logic             out_valid,
   input logic             out_ready,
   input logic [XLEN-1:0]  out_imm,
   input logic [2:0]       out_fmt,
   input logic             out_illegal,
   input logic [31:0]      out_instr,
   input logic [TAG_W-1:0] out_tag
);

   // A stalled output must not change until it is taken
   a_stall_stable: assert property (@(posedge clk) disable iff (rst)
      (out_valid && !out_ready && !flush) |=>
         (out_valid && $stable(out_imm) && $stable(out_fmt) &&
          $stable(out_illegal) && $stable(out_instr) && $stable(out_tag)));

   // Flush empties the buffer and reopens the input
   a_flush_empty: assert property (@(posedge clk) disable iff (rst)
      flush |=> (!out_valid && in_ready));

   // NONE format always carries a zero immediate
   a_none_zero: assert property (@(posedge clk) disable iff (rst)
      (out_fmt == 3'd0) |-> (out_imm == {XLEN{1'b0}}));

   // Illegal instructions never report a format
   a_illegal_none: assert property (@(posedge clk) disable iff (rst)
      out_illegal |-> (out_fmt == 3'd0));

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: decode table on XLEN=32 and XLEN=64
// instances fed identically, then backpressure, flush and reset in the
// full-buffer state.

module tb_imm_gen_pipe;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready;
   logic [31:0] in_instr, in_tag;

   logic        a_in_ready, a_out_valid, a_out_illegal;
   logic [31:0] a_out_imm, a_out_instr, a_out_tag;
   logic [2:0]  a_out_fmt;

   logic        b_in_ready, b_out_valid, b_out_illegal;
   logic [63:0] b_out_imm;
   logic [31:0] b_out_instr, b_out_tag;
   logic [2:0]  b_out_fmt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .TAG_W(32)) u_dut32 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(a_in_ready),
      .in_instr(in_instr), .in_tag(in_tag),
      .out_valid(a_out_valid), .out_ready(out_ready),
      .out_imm(a_out_imm), .out_fmt(a_out_fmt), .out_illegal(a_out_illegal),
      .out_instr(a_out_instr), .out_tag(a_out_tag)
   );

   imm_gen_pipe #(.XLEN(64), .TAG_W(32)) u_dut64 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(b_in_ready),
      .in_instr(in_instr), .in_tag(in_tag),
      .out_valid(b_out_valid), .out_ready(out_ready),
      .out_imm(b_out_imm), .out_fmt(b_out_fmt), .out_illegal(b_out_illegal),
      .out_instr(b_out_instr), .out_tag(b_out_tag)
   );

   task automatic check_value(input string tag, input logic [63:0] act,
                              input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Advance one cycle; sample point is 1 time unit after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] instr,
                        input logic [31:0] tag);
      in_valid = v;
      in_instr = instr;
      in_tag   = tag;
   endtask

   task automatic check_reset_values(input string ctx);
      check_value({ctx, "_valid"},   64'(a_out_valid),   64'd0);
      check_value({ctx, "_ready"},   64'(a_in_ready),    64'd1);
      check_value({ctx, "_imm"},     64'(a_out_imm),     64'd0);
      check_value({ctx, "_fmt"},     64'(a_out_fmt),     64'd0);
      check_value({ctx, "_illegal"}, 64'(a_out_illegal), 64'd0);
      check_value({ctx, "_instr"},   64'(a_out_instr),   64'd0);
      check_value({ctx, "_tag"},     64'(a_out_tag),     64'd0);
      check_value({ctx, "_valid64"}, 64'(b_out_valid),   64'd0);
      check_value({ctx, "_imm64"},   b_out_imm,          64'd0);
   endtask

   localparam int NV = 12;
   logic [31:0] v_instr [NV];
   logic [31:0] v_imm32 [NV];
   logic [63:0] v_imm64 [NV];
   logic [2:0]  v_fmt32 [NV];
   logic [2:0]  v_fmt64 [NV];
   logic        v_ill32 [NV];
   logic        v_ill64 [NV];

   task automatic set_vec(input int i, input logic [31:0] ins,
                          input logic [31:0] i32, input logic [63:0] i64,
                          input logic [2:0] f32, input logic [2:0] f64,
                          input logic l32, input logic l64);
      v_instr[i] = ins; v_imm32[i] = i32; v_imm64[i] = i64;
      v_fmt32[i] = f32; v_fmt64[i] = f64; v_ill32[i] = l32; v_ill64[i] = l64;
   endtask

   initial begin
      set_vec(0,  32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 3'd1, 1'b0, 1'b0);
      set_vec(1,  32'hFE112E23, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd2, 3'd2, 1'b0, 1'b0);
      set_vec(2,  32'hFE000FE3, 32'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFE, 3'd3, 3'd3, 1'b0, 1'b0);
      set_vec(3,  32'h123452B7, 32'h12345000, 64'h0000000012345000, 3'd4, 3'd4, 1'b0, 1'b0);
      set_vec(4,  32'h001000EF, 32'h00000800, 64'h0000000000000800, 3'd5, 3'd5, 1'b0, 1'b0);
      set_vec(5,  32'h0002D073, 32'h00000005, 64'h0000000000000005, 3'd6, 3'd6, 1'b0, 1'b0);
      set_vec(6,  32'h00000033, 32'h00000000, 64'h0000000000000000, 3'd0, 3'd0, 1'b0, 1'b0);
      set_vec(7,  32'h0000007F, 32'h00000000, 64'h0000000000000000, 3'd0, 3'd0, 1'b1, 1'b1);
      set_vec(8,  32'h800002B7, 32'h80000000, 64'hFFFFFFFF80000000, 3'd4, 3'd4, 1'b0, 1'b0);
      set_vec(9,  32'hFFF0009B, 32'h00000000, 64'hFFFFFFFFFFFFFFFF, 3'd0, 3'd1, 1'b1, 1'b0);
      set_vec(10, 32'h0000003B, 32'h00000000, 64'h0000000000000000, 3'd0, 3'd0, 1'b1, 1'b0);
      set_vec(11, 32'h00004073, 32'h00000000, 64'h0000000000000000, 3'd0, 3'd0, 1'b1, 1'b1);

      rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      step();
      step();
      check_reset_values("rst");
      rst = 1'b0;

      // Streaming decode, one cycle latency, out_ready held high
      out_ready = 1'b1;
      for (int i = 0; i < NV; i++) begin
         drive(1'b1, v_instr[i], 32'h100 + 32'(i));
         step();
         check_value($sformatf("valid[%0d]", i), 64'(a_out_valid), 64'd1);
         check_value($sformatf("imm32[%0d]", i), 64'(a_out_imm), 64'(v_imm32[i]));
         check_value($sformatf("fmt32[%0d]", i), 64'(a_out_fmt), 64'(v_fmt32[i]));
         check_value($sformatf("ill32[%0d]", i), 64'(a_out_illegal), 64'(v_ill32[i]));
         check_value($sformatf("instr[%0d]", i), 64'(a_out_instr), 64'(v_instr[i]));
         check_value($sformatf("tag[%0d]", i), 64'(a_out_tag), 64'h100 + 64'(i));
         check_value($sformatf("imm64[%0d]", i), b_out_imm, v_imm64[i]);
         check_value($sformatf("fmt64[%0d]", i), 64'(b_out_fmt), 64'(v_fmt64[i]));
         check_value($sformatf("ill64[%0d]", i), 64'(b_out_illegal), 64'(v_ill64[i]));
         check_value($sformatf("ready[%0d]", i), 64'(a_in_ready), 64'd1);
      end
      drive(1'b0, 32'h0, 32'h0);
      step();
      check_value("drain_valid", 64'(a_out_valid), 64'd0);

      // Backpressure: A and B fill the buffer, C waits
      out_ready = 1'b0;
      drive(1'b1, 32'h00100093, 32'h10);
      step();
      check_value("bp_a_valid", 64'(a_out_valid), 64'd1);
      check_value("bp_a_tag",   64'(a_out_tag),   64'h10);
      check_value("bp_a_ready", 64'(a_in_ready),  64'd1);
      drive(1'b1, 32'h00200093, 32'h14);
      step();
      check_value("bp_b_ready", 64'(a_in_ready), 64'd0);
      check_value("bp_b_hold",  64'(a_out_tag),  64'h10);
      drive(1'b1, 32'h00300093, 32'h18);
      step();
      check_value("bp_c_ready", 64'(a_in_ready), 64'd0);
      check_value("bp_c_hold",  64'(a_out_tag),  64'h10);
      check_value("bp_c_himm",  64'(a_out_imm),  64'd1);
      out_ready = 1'b1;
      step();
      check_value("bp_out_b_tag", 64'(a_out_tag), 64'h14);
      check_value("bp_out_b_imm", 64'(a_out_imm), 64'd2);
      check_value("bp_out_b_vld", 64'(a_out_valid), 64'd1);
      step();
      check_value("bp_out_c_tag", 64'(a_out_tag), 64'h18);
      check_value("bp_out_c_imm", 64'(a_out_imm), 64'd3);
      check_value("bp_out_c_vld", 64'(a_out_valid), 64'd1);
      drive(1'b0, 32'h0, 32'h0);
      step();
      check_value("bp_empty", 64'(a_out_valid), 64'd0);

      // Flush while full; the input offered during flush never appears
      out_ready = 1'b0;
      drive(1'b1, 32'h00100093, 32'h20);
      step();
      drive(1'b1, 32'h00200093, 32'h24);
      step();
      check_value("fl2_full", 64'(a_in_ready), 64'd0);
      flush = 1'b1;
      drive(1'b1, 32'h00300093, 32'h28);
      step();
      check_value("fl2_valid", 64'(a_out_valid), 64'd0);
      check_value("fl2_ready", 64'(a_in_ready),  64'd1);
      flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      out_ready = 1'b1;
      step();
      check_value("fl2_after", 64'(a_out_valid), 64'd0);

      // Flush in state ONE with an input accepted in the same cycle
      out_ready = 1'b0;
      drive(1'b1, 32'h00100093, 32'h30);
      step();
      flush = 1'b1;
      drive(1'b1, 32'h00500093, 32'h34);
      step();
      check_value("fl1_valid", 64'(a_out_valid), 64'd0);
      check_value("fl1_ready", 64'(a_in_ready),  64'd1);
      flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      out_ready = 1'b1;
      step();
      check_value("fl1_after", 64'(a_out_valid), 64'd0);

      // Reset (with flush) while full, input offered during reset
      out_ready = 1'b0;
      drive(1'b1, 32'h00100093, 32'h40);
      step();
      drive(1'b1, 32'h00200093, 32'h44);
      step();
      check_value("rs2_full", 64'(a_in_ready), 64'd0);
      rst = 1'b1;
      flush = 1'b1;
      drive(1'b1, 32'hFFF00093, 32'h48);
      step();
      rst = 1'b0;
      flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      check_reset_values("rs2");
      step();
      check_value("rs2_after", 64'(a_out_valid), 64'd0);

      // Block is usable again after reset
      out_ready = 1'b1;
      drive(1'b1, 32'hFE112E23, 32'h50);
      step();
      check_value("post_valid", 64'(a_out_valid), 64'd1);
      check_value("post_tag",   64'(a_out_tag),   64'h50);
      check_value("post_imm",   64'(a_out_imm),   64'hFFFFFFFC);
      drive(1'b0, 32'h0, 32'h0);
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
